// File: rtl/rx_8b9b.sv
// rx_8b9b: serial receiver for the 8b9b link.
// Deserialises one line bit per clock into WORD_WIDTH-bit words and recovers
// frame boundaries from the continuation bit that follows each word.
//
// Ports:
//   clk          bit clock, rising edge
//   rst_n        synchronous active-low reset
//   data_in      serial line, idle high
//   word_out     received word, held between strobes
//   word_valid   one-cycle strobe per received word
//   frame_end    with word_valid: word is last of its frame
//   word_index   with word_valid: 0-based position in frame, saturating
//   frame_active high from start-bit detection until the stop bit is sampled
//
// state   | meaning
// HUNT    | after reset; wait for a genuine high line level
// IDLE    | line idle; wait for a start bit
// RECEIVE | shifting in data bits, LSB first
// CHECK   | sampling continuation bit; present the word
module rx_8b9b #(
  parameter int WORD_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_in,
  output logic [WORD_WIDTH-1:0]  word_out,
  output logic                   word_valid,
  output logic                   frame_end,
  output logic [COUNT_WIDTH-1:0] word_index,
  output logic                   frame_active
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0]       CNT_LOAD = CNT_W'(WORD_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] IDX_MAX  = '1;

  typedef enum logic [1:0] {HUNT, IDLE, RECEIVE, CHECK} state_t;

  logic s;
  logic s_ok;

  // The synchroniser flops come out of reset high, so their first outputs
  // do not reflect the line. A parallel valid chain marks when s has been
  // refilled from data_in; until then HUNT ignores s, so a line held low
  // across reset is never mistaken for idle followed by a start bit.
  generate
    if (SYNC_STAGES == 0) begin : g_raw
      assign s    = data_in;
      assign s_ok = 1'b1;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] ok_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_q <= '1;
          ok_q   <= '0;
        end else begin
          sync_q[0] <= data_in;
          ok_q[0]   <= 1'b1;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
            ok_q[i]   <= ok_q[i-1];
          end
        end
      end

      assign s    = sync_q[SYNC_STAGES-1];
      assign s_ok = ok_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] idx_q, idx_d;
  logic [WORD_WIDTH-1:0]  word_d;
  logic                   valid_d;
  logic                   end_d;
  logic [COUNT_WIDTH-1:0] windex_d;
  logic                   active_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      shift_q      <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      frame_end    <= 1'b0;
      word_index   <= '0;
      frame_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      word_out     <= word_d;
      word_valid   <= valid_d;
      frame_end    <= end_d;
      word_index   <= windex_d;
      frame_active <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    word_d   = word_out;
    valid_d  = 1'b0;
    end_d    = frame_end;
    windex_d = word_index;
    active_d = frame_active;

    case (state_q)
      HUNT: begin
        if (s_ok && s) state_d = IDLE;
      end
      IDLE: begin
        if (!s) begin
          cnt_d    = CNT_LOAD;
          idx_d    = '0;
          active_d = 1'b1;
          state_d  = RECEIVE;
        end
      end
      RECEIVE: begin
        shift_d = {s, shift_q[WORD_WIDTH-1:1]};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = CHECK;
      end
      CHECK: begin
        word_d   = shift_q;
        valid_d  = 1'b1;
        end_d    = s;
        windex_d = idx_q;
        if (!s) begin
          // continuation bit low doubles as the next word's start bit
          cnt_d = CNT_LOAD;
          if (idx_q != IDX_MAX) idx_d = idx_q + COUNT_WIDTH'(1);
          state_d = RECEIVE;
        end else begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = HUNT;
    endcase
  end

endmodule

// File: tb/tb_rx_8b9b.sv
// Directed testbench for rx_8b9b. Three instances share one line and reset:
// default parameters, SYNC_STAGES=0, and COUNT_WIDTH=2. Strobes from each are
// logged with their cycle number and compared against hand-computed values.
module tb_rx_8b9b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line = 1'b1;

  always #5 clk = ~clk;

  logic [7:0] wo0, wo1, wo2;
  logic       v0, v1, v2, fe0, fe1, fe2, fa0, fa1, fa2;
  logic [7:0] ix0, ix1;
  logic [1:0] ix2;

  rx_8b9b dut_main (
    .clk(clk), .rst_n(rst_n), .data_in(line),
    .word_out(wo0), .word_valid(v0), .frame_end(fe0),
    .word_index(ix0), .frame_active(fa0)
  );

  rx_8b9b #(.WORD_WIDTH(8), .SYNC_STAGES(0), .COUNT_WIDTH(8)) dut_nosync (
    .clk(clk), .rst_n(rst_n), .data_in(line),
    .word_out(wo1), .word_valid(v1), .frame_end(fe1),
    .word_index(ix1), .frame_active(fa1)
  );

  rx_8b9b #(.WORD_WIDTH(8), .SYNC_STAGES(2), .COUNT_WIDTH(2)) dut_cw2 (
    .clk(clk), .rst_n(rst_n), .data_in(line),
    .word_out(wo2), .word_valid(v2), .frame_end(fe2),
    .word_index(ix2), .frame_active(fa2)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] w;
    logic [7:0] idx;
    logic       fe;
    logic       fa;
    int         t;
  } strobe_t;

  strobe_t q0[$], q1[$], q2[$];

  always @(negedge clk) begin
    if (v0) q0.push_back('{wo0, ix0, fe0, fa0, cyc});
    if (v1) q1.push_back('{wo1, ix1, fe1, fa1, cyc});
    if (v2) q2.push_back('{wo2, {6'b0, ix2}, fe2, fa2, cyc});
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fr[$];
  int t0;

  task automatic tick(input logic b);
    line = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b1);
  endtask

  // start bit, then each word LSB first followed by its continuation bit
  task automatic send_frame();
    t0 = cyc + 1;
    tick(1'b0);
    for (int k = 0; k < fr.size(); k++) begin
      for (int b = 0; b < 8; b++) tick(fr[k][b]);
      tick(k == fr.size() - 1);
    end
  endtask

  task automatic clear_logs();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  logic [7:0] e3[3]  = '{8'h01, 8'h80, 8'hFF};
  logic [7:0] ez[3]  = '{8'h00, 8'h00, 8'h3C};
  logic [7:0] ezi[3] = '{8'd0, 8'd1, 8'd0};
  logic       ezf[3] = '{1'b0, 1'b1, 1'b1};
  logic [7:0] e6i[7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd0};

  initial begin
    // reset state
    line  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", v0, 0);
    check("rst_end", fe0, 0);
    check("rst_active", fa0, 0);
    check("rst_word", wo0, 0);
    check("rst_index", ix0, 0);
    rst_n = 1'b1;
    idle(6);

    // single word 0xA5
    clear_logs();
    fr = '{8'hA5};
    send_frame();
    idle(14);
    check("a5_count", q0.size(), 1);
    if (q0.size() == 1) begin
      check("a5_word", q0[0].w, 8'hA5);
      check("a5_end", q0[0].fe, 1);
      check("a5_index", q0[0].idx, 0);
      check("a5_active_at_end", q0[0].fa, 0);
      check("a5_latency", q0[0].t - t0, 11);
    end

    // three-word frame back-to-back
    clear_logs();
    fr = '{8'h01, 8'h80, 8'hFF};
    send_frame();
    idle(14);
    check("f3_count", q0.size(), 3);
    if (q0.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("f3_word%0d", i), q0[i].w, e3[i]);
        check($sformatf("f3_index%0d", i), q0[i].idx, i);
        check($sformatf("f3_end%0d", i), q0[i].fe, (i == 2));
        check($sformatf("f3_active%0d", i), q0[i].fa, (i != 2));
        if (i > 0) check($sformatf("f3_spacing%0d", i), q0[i].t - q0[i-1].t, 9);
      end
    end
    check("f3_active_after", fa0, 0);

    // all-zero words, one-cycle gap, then 0x3C
    clear_logs();
    fr = '{8'h00, 8'h00};
    send_frame();
    idle(1);
    fr = '{8'h3C};
    send_frame();
    idle(14);
    check("zz_count", q0.size(), 3);
    if (q0.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("zz_word%0d", i), q0[i].w, ez[i]);
        check($sformatf("zz_index%0d", i), q0[i].idx, ezi[i]);
        check($sformatf("zz_end%0d", i), q0[i].fe, ezf[i]);
      end
    end

    // reset in the middle of a word with the line low
    clear_logs();
    tick(1'b0);
    repeat (4) tick(1'b0);
    rst_n = 1'b0;
    tick(1'b0);
    check("mid_rst_active", fa0, 0);
    check("mid_rst_valid", v0, 0);
    tick(1'b0);
    rst_n = 1'b1;
    repeat (5) tick(1'b0);
    idle(3);
    fr = '{8'h5A};
    send_frame();
    idle(14);
    check("mr_count", q0.size(), 1);
    if (q0.size() == 1) begin
      check("mr_word", q0[0].w, 8'h5A);
      check("mr_index", q0[0].idx, 0);
      check("mr_end", q0[0].fe, 1);
    end
    check("mr_nosync_count", q1.size(), 1);
    if (q1.size() == 1) check("mr_nosync_word", q1[0].w, 8'h5A);

    // no synchroniser: 0xC3 latency
    clear_logs();
    fr = '{8'hC3};
    send_frame();
    idle(14);
    check("c3_count", q1.size(), 1);
    if (q1.size() == 1) begin
      check("c3_word", q1[0].w, 8'hC3);
      check("c3_latency", q1[0].t - t0, 9);
    end
    if (q0.size() == 1) check("c3_main_latency", q0[0].t - t0, 11);

    // saturating index with COUNT_WIDTH=2, then a fresh frame
    clear_logs();
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame();
    idle(3);
    fr = '{8'h77};
    send_frame();
    idle(14);
    check("sat_count", q2.size(), 7);
    if (q2.size() == 7) begin
      for (int i = 0; i < 7; i++)
        check($sformatf("sat_index%0d", i), q2[i].idx, e6i[i]);
      check("sat_word5", q2[5].w, 8'h66);
      check("sat_end5", q2[5].fe, 1);
    end
    if (q0.size() == 7) check("sat_main_index5", q0[5].idx, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
